// File: rtl/sprite_draw_sequencer.sv
// Per-frame draw scheduler: starts each enabled sprite drawer in index order and
// forwards the active drawer's pixel stream to the shared VGA write port.
module sprite_draw_sequencer #(
  parameter int NUM_SPRITES    = 3,
  parameter int X_WIDTH        = 9,
  parameter int Y_WIDTH        = 8,
  parameter int COLOUR_WIDTH   = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                draw,
  input  logic [NUM_SPRITES-1:0]              enable_mask,
  input  logic [NUM_SPRITES*X_WIDTH-1:0]      spr_x,
  input  logic [NUM_SPRITES*Y_WIDTH-1:0]      spr_y,
  input  logic [NUM_SPRITES*COLOUR_WIDTH-1:0] spr_colour,
  input  logic [NUM_SPRITES-1:0]              spr_write,
  input  logic [NUM_SPRITES-1:0]              spr_done,
  output logic [NUM_SPRITES-1:0]              spr_start,
  output logic [X_WIDTH-1:0]                  x_draw,
  output logic [Y_WIDTH-1:0]                  y_draw,
  output logic [COLOUR_WIDTH-1:0]             colour,
  output logic                                VGA_write,
  output logic                                draw_done,
  output logic                                busy,
  output logic                                timeout_err
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SELECT, ACTIVE, ADVANCE, DONE} state_t;

  state_t                     state_reg, state_next;
  logic [IDX_W-1:0]           index_reg, index_next;
  logic [NUM_SPRITES-1:0]     mask_reg, mask_next;
  logic [WD_W-1:0]            wd_reg, wd_next;
  logic                       err_reg, err_next;
  logic [NUM_SPRITES-1:0]     spr_start_reg, spr_start_next;
  logic                       busy_reg, busy_next;
  logic                       draw_done_reg, draw_done_next;
  logic [X_WIDTH-1:0]         x_reg;
  logic [Y_WIDTH-1:0]         y_reg;
  logic [COLOUR_WIDTH-1:0]    colour_reg;
  logic                       vga_write_reg;

  // Unpack the drawer buses so the active slice can be picked by index.
  logic [X_WIDTH-1:0]      x_arr      [NUM_SPRITES];
  logic [Y_WIDTH-1:0]      y_arr      [NUM_SPRITES];
  logic [COLOUR_WIDTH-1:0] colour_arr [NUM_SPRITES];

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slice
    assign x_arr[gi]      = spr_x[gi*X_WIDTH +: X_WIDTH];
    assign y_arr[gi]      = spr_y[gi*Y_WIDTH +: Y_WIDTH];
    assign colour_arr[gi] = spr_colour[gi*COLOUR_WIDTH +: COLOUR_WIDTH];
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    mask_next  = mask_reg;
    wd_next    = wd_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (draw) begin
          mask_next  = enable_mask;
          index_next = '0;
          state_next = SELECT;
        end
      end
      SELECT: begin
        if (!draw) begin
          state_next = IDLE;
        end else if (mask_reg[index_reg]) begin
          state_next = ACTIVE;
          wd_next    = '0;
        end else begin
          state_next = ADVANCE;
        end
      end
      ACTIVE: begin
        // Done is checked before the watchdog so a coincident done is not an error.
        if (!draw) begin
          state_next = IDLE;
        end else if (spr_done[index_reg]) begin
          state_next = ADVANCE;
        end else if (wd_reg == WD_MAX) begin
          err_next   = 1'b1;
          state_next = ADVANCE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      ADVANCE: begin
        if (!draw) begin
          state_next = IDLE;
        end else if (index_reg == LAST_IDX) begin
          state_next = DONE;
        end else begin
          index_next = index_reg + 1'b1;
          state_next = SELECT;
        end
      end
      DONE: begin
        if (!draw) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    spr_start_next = '0;
    if (state_next == ACTIVE) spr_start_next[index_next] = 1'b1;
    busy_next      = (state_next == SELECT) || (state_next == ACTIVE) || (state_next == ADVANCE);
    draw_done_next = (state_next == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      index_reg     <= '0;
      mask_reg      <= '0;
      wd_reg        <= '0;
      err_reg       <= 1'b0;
      spr_start_reg <= '0;
      busy_reg      <= 1'b0;
      draw_done_reg <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      colour_reg    <= '0;
      vga_write_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      index_reg     <= index_next;
      mask_reg      <= mask_next;
      wd_reg        <= wd_next;
      err_reg       <= err_next;
      spr_start_reg <= spr_start_next;
      busy_reg      <= busy_next;
      draw_done_reg <= draw_done_next;
      if (state_reg == ACTIVE) begin
        x_reg      <= x_arr[index_reg];
        y_reg      <= y_arr[index_reg];
        colour_reg <= colour_arr[index_reg];
      end
      // Gating with draw keeps an aborted pass from emitting a trailing pixel.
      vga_write_reg <= (state_reg == ACTIVE) && draw && spr_write[index_reg];
    end
  end

  assign spr_start   = spr_start_reg;
  assign x_draw      = x_reg;
  assign y_draw      = y_reg;
  assign colour      = colour_reg;
  assign VGA_write   = vga_write_reg;
  assign draw_done   = draw_done_reg;
  assign busy        = busy_reg;
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench for sprite_draw_sequencer: simple drawer models driven from
// tasks, outputs sampled on the falling clock edge.
module tb_sprite_draw_sequencer;
  localparam int NS = 3;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             draw;
  logic [NS-1:0]    enable_mask;
  logic [NS*XW-1:0] spr_x;
  logic [NS*YW-1:0] spr_y;
  logic [NS*CW-1:0] spr_colour;
  logic [NS-1:0]    spr_write;
  logic [NS-1:0]    spr_done;
  logic [NS-1:0]    spr_start;
  logic [XW-1:0]    x_draw;
  logic [YW-1:0]    y_draw;
  logic [CW-1:0]    colour;
  logic             VGA_write;
  logic             draw_done;
  logic             busy;
  logic             timeout_err;

  sprite_draw_sequencer #(
    .NUM_SPRITES(NS), .X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .draw(draw), .enable_mask(enable_mask),
    .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour),
    .spr_write(spr_write), .spr_done(spr_done), .spr_start(spr_start),
    .x_draw(x_draw), .y_draw(y_draw), .colour(colour), .VGA_write(VGA_write),
    .draw_done(draw_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int         n_start [NS];
  int         n_vga, n_pix_bad, n_bad_start, done_cycle, err_cycle;
  logic       busy1, busy_at_done, vga_at_abort, vga_after_abort;
  logic [2:0] first_start, start_after_abort;

  // One draw pass. Drawers write 4 pixels then pulse done unless hung; rogue
  // drawers strobe write whenever they are not started. enable_mask is flipped
  // after the first cycle to exercise the frozen mask.
  task automatic run_pass(input logic [2:0] mask, input int max_cycles,
                          input logic [2:0] hang, input logic [2:0] rogue, input int abort_at);
    int         cnt [NS];
    logic       pw_prev, pw;
    logic [8:0] px_prev, px;
    logic [7:0] py_prev, py;
    logic [5:0] pc_prev, pc;
    logic       aborted;
    for (int i = 0; i < NS; i++) begin
      cnt[i] = 0;
      n_start[i] = 0;
    end
    n_vga = 0; n_pix_bad = 0; n_bad_start = 0; done_cycle = -1; err_cycle = -1;
    busy1 = 1'b0; busy_at_done = 1'b1; first_start = '0;
    vga_at_abort = 1'b0; vga_after_abort = 1'b1; start_after_abort = '1;
    pw_prev = 1'b0; px_prev = '0; py_prev = '0; pc_prev = '0; aborted = 1'b0;
    draw = 1'b1;
    enable_mask = mask;
    for (int cyc = 1; cyc <= max_cycles; cyc++) begin
      @(negedge clock);
      if (aborted) begin
        start_after_abort = spr_start;
        vga_after_abort   = VGA_write;
        break;
      end
      if (cyc == 1) busy1 = busy;
      if (timeout_err === 1'b1 && err_cycle < 0) err_cycle = cyc;
      if (spr_start != 3'b000 && first_start == 3'b000) first_start = spr_start;
      if ((spr_start & (spr_start - 3'd1)) != 3'b000) n_bad_start++;
      for (int i = 0; i < NS; i++) if (spr_start[i]) n_start[i]++;
      if (VGA_write === 1'b1) n_vga++;
      if (VGA_write !== pw_prev) n_pix_bad++;
      else if (pw_prev && (x_draw !== px_prev || y_draw !== py_prev || colour !== pc_prev))
        n_pix_bad++;
      if (draw_done === 1'b1) begin
        done_cycle   = cyc;
        busy_at_done = busy;
        break;
      end
      spr_write = '0;
      spr_done  = '0;
      pw = 1'b0; px = '0; py = '0; pc = '0;
      for (int i = 0; i < NS; i++) begin
        if (spr_start[i]) begin
          if (!hang[i]) begin
            if (cnt[i] < 4) begin
              px = 9'(i*64 + cnt[i]);
              py = 8'(i*32 + cnt[i] + 1);
              pc = 6'(i*8 + cnt[i] + 2);
              spr_x[i*XW +: XW] = px;
              spr_y[i*YW +: YW] = py;
              spr_colour[i*CW +: CW] = pc;
              spr_write[i] = 1'b1;
              pw = 1'b1;
            end else if (cnt[i] == 4) begin
              spr_done[i] = 1'b1;
            end
            cnt[i]++;
          end
        end else begin
          cnt[i] = 0;
          if (rogue[i]) begin
            spr_write[i] = 1'b1;
            spr_x[i*XW +: XW] = 9'h1FF;
            spr_y[i*YW +: YW] = 8'hFF;
            spr_colour[i*CW +: CW] = 6'h3F;
          end
        end
      end
      pw_prev = pw; px_prev = px; py_prev = py; pc_prev = pc;
      if (cyc == 1) enable_mask = ~mask;
      if (cyc == abort_at) begin
        vga_at_abort = VGA_write;
        draw    = 1'b0;
        aborted = 1'b1;
      end
    end
    spr_write = '0;
    spr_done  = '0;
  endtask

  task automatic end_pass(input string name);
    draw = 1'b0;
    @(negedge clock);
    total++;
    if (draw_done !== 1'b0) begin
      bad++;
      $display("FAIL %s draw_done_fall: got %b want 0", name, draw_done);
    end
  endtask

  task automatic check_pass(input string name, input int exp_done,
                            input int e0, input int e1, input int e2, input int exp_vga);
    total++;
    if (done_cycle !== exp_done) begin
      bad++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cycle, exp_done);
    end
    total++;
    if (n_start[0] !== e0 || n_start[1] !== e1 || n_start[2] !== e2) begin
      bad++;
      $display("FAIL %s start_cycles: got %0d/%0d/%0d want %0d/%0d/%0d",
               name, n_start[0], n_start[1], n_start[2], e0, e1, e2);
    end
    total++;
    if (n_vga !== exp_vga) begin
      bad++; $display("FAIL %s vga_writes: got %0d want %0d", name, n_vga, exp_vga);
    end
    total++;
    if (n_pix_bad !== 0 || n_bad_start !== 0) begin
      bad++;
      $display("FAIL %s pixel_path: got %0d pixel errors %0d bad start vectors want 0/0",
               name, n_pix_bad, n_bad_start);
    end
    total++;
    if (busy1 !== 1'b1 || busy_at_done !== 1'b0) begin
      bad++;
      $display("FAIL %s busy: got start=%b done=%b want 1/0", name, busy1, busy_at_done);
    end
    $display("%s: done at cycle %0d, starts %0d/%0d/%0d, vga writes %0d",
             name, done_cycle, n_start[0], n_start[1], n_start[2], n_vga);
  endtask

  task automatic test_reset;
    reset = 1'b0; draw = 1'b0; enable_mask = '0;
    spr_x = '0; spr_y = '0; spr_colour = '0; spr_write = '0; spr_done = '0;
    repeat (3) @(negedge clock);
    total++;
    if ({spr_start, VGA_write, draw_done, busy, timeout_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got start=%b vga=%b done=%b busy=%b err=%b want all 0",
               spr_start, VGA_write, draw_done, busy, timeout_err);
    end
    total++;
    if ({x_draw, y_draw, colour} !== 23'b0) begin
      bad++;
      $display("FAIL reset_pixel: got x=%h y=%h c=%h want 0", x_draw, y_draw, colour);
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || draw_done !== 1'b0) begin
      bad++; $display("FAIL reset_idle: got busy=%b done=%b want 0/0", busy, draw_done);
    end
    $display("reset: outputs cleared");
  endtask

  task automatic test_full_pass;
    run_pass(3'b111, 60, 3'b000, 3'b000, 0);
    check_pass("full_111", 22, 5, 5, 5, 12);
    total++;
    if (first_start !== 3'b001) begin
      bad++; $display("FAIL full_111 first_start: got %b want 001", first_start);
    end
    @(negedge clock);
    total++;
    if (draw_done !== 1'b1) begin
      bad++; $display("FAIL full_111 draw_done_hold: got %b want 1", draw_done);
    end
    end_pass("full_111");
  endtask

  task automatic test_mask_101;
    run_pass(3'b101, 60, 3'b000, 3'b010, 0);
    check_pass("mask_101", 17, 5, 0, 5, 8);
    end_pass("mask_101");
  endtask

  task automatic test_mask_000;
    run_pass(3'b000, 40, 3'b000, 3'b000, 0);
    check_pass("mask_000", 7, 0, 0, 0, 0);
    end_pass("mask_000");
  endtask

  task automatic test_timeout;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++; $display("FAIL timeout_pre: got %b want 0", timeout_err);
    end
    run_pass(3'b111, 80, 3'b010, 3'b000, 0);
    check_pass("timeout", 33, 5, 16, 5, 8);
    total++;
    if (err_cycle !== 25) begin
      bad++; $display("FAIL timeout err_cycle: got %0d want 25", err_cycle);
    end
    end_pass("timeout");
    run_pass(3'b001, 40, 3'b000, 3'b000, 0);
    check_pass("after_timeout", 12, 5, 0, 0, 4);
    total++;
    if (err_cycle !== 1 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL sticky_err: got first=%0d now=%b want 1/1", err_cycle, timeout_err);
    end
    end_pass("after_timeout");
  endtask

  task automatic test_abort;
    logic saw_done, saw_busy;
    run_pass(3'b111, 60, 3'b000, 3'b000, 12);
    total++;
    if (vga_at_abort !== 1'b1) begin
      bad++; $display("FAIL abort vga_before: got %b want 1", vga_at_abort);
    end
    total++;
    if (start_after_abort !== 3'b000 || vga_after_abort !== 1'b0) begin
      bad++;
      $display("FAIL abort outputs: got start=%b vga=%b want 000/0",
               start_after_abort, vga_after_abort);
    end
    total++;
    if (done_cycle !== -1) begin
      bad++; $display("FAIL abort early_done: got %0d want -1", done_cycle);
    end
    saw_done = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (draw_done !== 1'b0) saw_done = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
      @(negedge clock);
    end
    total++;
    if (saw_done !== 1'b0 || saw_busy !== 1'b0) begin
      bad++; $display("FAIL abort idle: got done=%b busy=%b want 0/0", saw_done, saw_busy);
    end
    $display("abort: pass dropped during sprite 1");
    run_pass(3'b111, 60, 3'b000, 3'b000, 0);
    check_pass("restart", 22, 5, 5, 5, 12);
    total++;
    if (first_start !== 3'b001) begin
      bad++; $display("FAIL restart first_start: got %b want 001", first_start);
    end
    end_pass("restart");
  endtask

  task automatic test_reset_mid_active;
    draw = 1'b1; enable_mask = 3'b111;
    repeat (2) @(negedge clock);
    total++;
    if (spr_start !== 3'b001) begin
      bad++; $display("FAIL rst_mid start_pre: got %b want 001", spr_start);
    end
    spr_x[8:0] = 9'h155; spr_y[7:0] = 8'hAA; spr_colour[5:0] = 6'h2A; spr_write = 3'b001;
    @(negedge clock);
    total++;
    if (VGA_write !== 1'b1 || x_draw !== 9'h155 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid pre: got vga=%b x=%h err=%b want 1/155/1", VGA_write, x_draw, timeout_err);
    end
    reset = 1'b0; draw = 1'b0;
    #1;
    total++;
    if ({spr_start, VGA_write, draw_done, busy, timeout_err} !== 7'b0 ||
        {x_draw, y_draw, colour} !== 23'b0) begin
      bad++;
      $display("FAIL rst_mid outputs: got start=%b vga=%b err=%b x=%h y=%h c=%h want all 0",
               spr_start, VGA_write, timeout_err, x_draw, y_draw, colour);
    end
    @(negedge clock);
    reset = 1'b1; spr_write = '0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0 || spr_start !== 3'b000 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid idle: got busy=%b start=%b err=%b want 0/000/0", busy, spr_start, timeout_err);
    end
    $display("reset_mid_active: cleared during sprite 0");
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_mask_101();
    test_mask_000();
    test_timeout();
    test_abort();
    test_reset_mid_active();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
